// File: rtl/mc_port_arbiter_if.sv
// Signal bundle between the phold cores, the port arbiter and one MC request/response port.
// The arbiter connects through the slave modport. The cores and MC connect through master.
interface mc_port_arbiter_if #(
   parameter int NUM_REQ      = 4,
   parameter int RTNCTL_WIDTH = 32
);
   localparam int TW = RTNCTL_WIDTH - 8;

   logic [NUM_REQ-1:0]      req_vld;
   logic [3*NUM_REQ-1:0]    req_cmd;
   logic [4*NUM_REQ-1:0]    req_scmd;
   logic [2*NUM_REQ-1:0]    req_size;
   logic [48*NUM_REQ-1:0]   req_vadr;
   logic [64*NUM_REQ-1:0]   req_data;
   logic [TW*NUM_REQ-1:0]   req_rtnctl;
   logic [NUM_REQ-1:0]      req_stall;

   logic [NUM_REQ-1:0]      rsp_vld;
   logic [2:0]              rsp_cmd;
   logic [3:0]              rsp_scmd;
   logic [63:0]             rsp_data;
   logic [TW-1:0]           rsp_rtnctl;
   logic [NUM_REQ-1:0]      rsp_stall;

   logic                    mc_rq_vld;
   logic [2:0]              mc_rq_cmd;
   logic [3:0]              mc_rq_scmd;
   logic [47:0]             mc_rq_vadr;
   logic [1:0]              mc_rq_size;
   logic [63:0]             mc_rq_data;
   logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
   logic                    mc_rq_flush;
   logic                    mc_rq_stall;

   logic                    mc_rs_vld;
   logic [2:0]              mc_rs_cmd;
   logic [3:0]              mc_rs_scmd;
   logic [63:0]             mc_rs_data;
   logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
   logic                    mc_rs_stall;

   logic                    err_bad_rtnctl;
   logic                    idle;

   modport slave (
      input  req_vld, req_cmd, req_scmd, req_size, req_vadr, req_data, req_rtnctl,
      output req_stall,
      output rsp_vld, rsp_cmd, rsp_scmd, rsp_data, rsp_rtnctl,
      input  rsp_stall,
      output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size, mc_rq_data,
      output mc_rq_rtnctl, mc_rq_flush,
      input  mc_rq_stall,
      input  mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
      output mc_rs_stall,
      output err_bad_rtnctl, idle
   );

   modport master (
      output req_vld, req_cmd, req_scmd, req_size, req_vadr, req_data, req_rtnctl,
      input  req_stall,
      input  rsp_vld, rsp_cmd, rsp_scmd, rsp_data, rsp_rtnctl,
      output rsp_stall,
      input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size, mc_rq_data,
      input  mc_rq_rtnctl, mc_rq_flush,
      output mc_rq_stall,
      output mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
      input  mc_rs_stall,
      input  err_bad_rtnctl, idle
   );
endinterface

// File: rtl/mc_port_arbiter.sv
// Round-robin sharing of one MC port among NUM_REQ cores, with tagged responses steered back through a FIFO.
// Optional per-requester read limit: define MC_ARB_OUTSTANDING_LIMIT_EN.
module mc_port_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int RTNCTL_WIDTH    = 32,
   parameter int RS_FIFO_DEPTH   = 8,
   parameter int RS_STALL_MARGIN = 4,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   mc_port_arbiter_if.slave bus
);
   localparam int TW = RTNCTL_WIDTH - 8;
   localparam int IW = $clog2(NUM_REQ);
   localparam int AW = $clog2(RS_FIFO_DEPTH);
   localparam logic [AW:0] FIFO_FULL = (AW+1)'(RS_FIFO_DEPTH);
   localparam logic [AW:0] STALL_TH  = (AW+1)'(RS_FIFO_DEPTH - RS_STALL_MARGIN);

   typedef struct packed {
      logic [2:0]              cmd;
      logic [3:0]              scmd;
      logic [63:0]             data;
      logic [RTNCTL_WIDTH-1:0] rtnctl;
   } rs_entry_t;

   logic [IW-1:0]      ptr;
   logic [NUM_REQ-1:0] eligible;
   logic               gnt_vld;
   logic [IW-1:0]      gnt_idx;
   logic [NUM_REQ-1:0] gnt_onehot;
   logic [2:0]         sel_cmd;
   logic [3:0]         sel_scmd;
   logic [1:0]         sel_size;
   logic [47:0]        sel_vadr;
   logic [63:0]        sel_data;
   logic [TW-1:0]      sel_rtnctl;

   logic                    rq_vld;
   logic [2:0]              rq_cmd;
   logic [3:0]              rq_scmd;
   logic [47:0]             rq_vadr;
   logic [1:0]              rq_size;
   logic [63:0]             rq_data;
   logic [RTNCTL_WIDTH-1:0] rq_rtnctl;

   rs_entry_t          fifo_mem [RS_FIFO_DEPTH];
   rs_entry_t          head;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;
   logic [AW:0]        count_next;
   logic               head_vld;
   logic [7:0]         head_idx;
   logic               head_ok;
   logic [NUM_REQ-1:0] rsp_vld_i;
   logic               push;
   logic               pop;
   logic               full;
   logic               rs_stall;
   logic               err_bad;
   logic               cnt_zero;

   // Search from ptr upward first, then wrap to the requesters below ptr.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      if (rst_n && !bus.mc_rq_stall) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_vld && bus.req_vld[i] && eligible[i] && (IW'(i) >= ptr)) begin
               gnt_vld = 1'b1;
               gnt_idx = IW'(i);
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_vld && bus.req_vld[i] && eligible[i]) begin
               gnt_vld = 1'b1;
               gnt_idx = IW'(i);
            end
         end
      end
   end

   always_comb begin
      gnt_onehot = '0;
      sel_cmd    = '0;
      sel_scmd   = '0;
      sel_size   = '0;
      sel_vadr   = '0;
      sel_data   = '0;
      sel_rtnctl = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         gnt_onehot[i] = gnt_vld && (gnt_idx == IW'(i));
         if (gnt_onehot[i]) begin
            sel_cmd    = bus.req_cmd[i*3 +: 3];
            sel_scmd   = bus.req_scmd[i*4 +: 4];
            sel_size   = bus.req_size[i*2 +: 2];
            sel_vadr   = bus.req_vadr[i*48 +: 48];
            sel_data   = bus.req_data[i*64 +: 64];
            sel_rtnctl = bus.req_rtnctl[i*TW +: TW];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         rq_vld    <= 1'b0;
         rq_cmd    <= '0;
         rq_scmd   <= '0;
         rq_vadr   <= '0;
         rq_size   <= '0;
         rq_data   <= '0;
         rq_rtnctl <= '0;
      end else begin
         rq_vld <= gnt_vld;
         if (gnt_vld) begin
            ptr       <= (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            rq_cmd    <= sel_cmd;
            rq_scmd   <= sel_scmd;
            rq_vadr   <= sel_vadr;
            rq_size   <= sel_size;
            rq_data   <= sel_data;
            rq_rtnctl <= {8'(gnt_idx), sel_rtnctl};
         end
      end
   end

   // A head with an out-of-range index never matches a requester, so it pops unconditionally.
   assign head     = fifo_mem[rd_ptr];
   assign head_vld = (count != '0);
   assign head_idx = head.rtnctl[RTNCTL_WIDTH-1 -: 8];
   assign head_ok  = (head_idx < 8'(NUM_REQ));
   assign full     = (count == FIFO_FULL);
   assign pop      = head_vld && !(|(rsp_vld_i & bus.rsp_stall));
   assign push     = bus.mc_rs_vld && (!full || pop);

   always_comb begin
      rsp_vld_i = '0;
      for (int i = 0; i < NUM_REQ; i++)
         rsp_vld_i[i] = head_vld && (head_idx == 8'(i));
   end

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + 1'b1;
      else if (pop && !push)
         count_next = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= '{cmd: bus.mc_rs_cmd, scmd: bus.mc_rs_scmd,
                               data: bus.mc_rs_data, rtnctl: bus.mc_rs_rtnctl};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rs_stall <= 1'b0;
         err_bad  <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count    <= count_next;
         rs_stall <= (count_next >= STALL_TH);
         if (pop && !head_ok)
            err_bad <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n && bus.mc_rs_vld && full && !pop)
         $display("%m: response fifo overflow at %0t, entry dropped", $time);
   end
`endif

`ifdef MC_ARB_OUTSTANDING_LIMIT_EN
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   logic [CW-1:0]      rd_cnt [NUM_REQ];
   logic [NUM_REQ-1:0] rd_inc;
   logic [NUM_REQ-1:0] rd_dec;

   always_comb begin
      rd_inc   = '0;
      rd_dec   = '0;
      eligible = '0;
      cnt_zero = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         rd_inc[i]   = gnt_onehot[i] && (sel_cmd == 3'd1);
         rd_dec[i]   = pop && rsp_vld_i[i] && (head.cmd == 3'd2) && (rd_cnt[i] != '0);
         eligible[i] = (rd_cnt[i] != CW'(MAX_OUTSTANDING));
         cnt_zero    = cnt_zero && (rd_cnt[i] == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++)
            rd_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_inc[i] && !rd_dec[i])
               rd_cnt[i] <= rd_cnt[i] + 1'b1;
            else if (rd_dec[i] && !rd_inc[i])
               rd_cnt[i] <= rd_cnt[i] - 1'b1;
         end
      end
   end
`else
   assign eligible = '1;
   assign cnt_zero = 1'b1;
`endif

   assign bus.req_stall      = ~gnt_onehot;
   assign bus.rsp_vld        = rsp_vld_i;
   assign bus.rsp_cmd        = head.cmd;
   assign bus.rsp_scmd       = head.scmd;
   assign bus.rsp_data       = head.data;
   assign bus.rsp_rtnctl     = head.rtnctl[TW-1:0];
   assign bus.mc_rq_vld      = rq_vld;
   assign bus.mc_rq_cmd      = rq_cmd;
   assign bus.mc_rq_scmd     = rq_scmd;
   assign bus.mc_rq_vadr     = rq_vadr;
   assign bus.mc_rq_size     = rq_size;
   assign bus.mc_rq_data     = rq_data;
   assign bus.mc_rq_rtnctl   = rq_rtnctl;
   assign bus.mc_rq_flush    = 1'b0;
   assign bus.mc_rs_stall    = rs_stall;
   assign bus.err_bad_rtnctl = err_bad;
   assign bus.idle           = !rq_vld && !head_vld && cnt_zero;
endmodule

// File: tb/tb_mc_port_arbiter.sv
// Directed bench for mc_port_arbiter: arbitration order, MC stall, response steering,
// back-pressure, optional read limit and async reset.
module tb_mc_port_arbiter;
   localparam int N  = 4;
   localparam int RW = 32;
   localparam int TW = RW - 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   mc_port_arbiter_if #(.NUM_REQ(N), .RTNCTL_WIDTH(RW)) bus ();

   mc_port_arbiter #(
      .NUM_REQ(N), .RTNCTL_WIDTH(RW), .RS_FIFO_DEPTH(8),
      .RS_STALL_MARGIN(4), .MAX_OUTSTANDING(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   // cycle boundary: inputs change 1 time unit after the rising edge, outputs are read at the falling edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic init_inputs();
      bus.req_vld      = '0;
      bus.rsp_stall    = '0;
      bus.mc_rq_stall  = 1'b0;
      bus.mc_rs_vld    = 1'b0;
      bus.mc_rs_cmd    = '0;
      bus.mc_rs_scmd   = '0;
      bus.mc_rs_data   = '0;
      bus.mc_rs_rtnctl = '0;
      for (int i = 0; i < N; i++) begin
         bus.req_cmd[i*3 +: 3]     = 3'd2;
         bus.req_scmd[i*4 +: 4]    = 4'(i);
         bus.req_size[i*2 +: 2]    = 2'd3;
         bus.req_vadr[i*48 +: 48]  = 48'h1000_0000 + 48'(i) * 48'h100;
         bus.req_data[i*64 +: 64]  = 64'hD0D0_0000_0000_0000 + 64'(i);
         bus.req_rtnctl[i*TW +: TW] = 24'h000100 + 24'(i);
      end
   endtask

   task automatic test_reset();
      bus.req_vld = 4'hF;
      #3;
      n_cmp++; if (bus.req_stall !== 4'hF) begin n_bad++; $display("FAIL reset_req_stall: got %b want 1111", bus.req_stall); end
      n_cmp++; if (bus.mc_rq_vld !== 1'b0) begin n_bad++; $display("FAIL reset_mc_rq_vld: got %b want 0", bus.mc_rq_vld); end
      n_cmp++; if (bus.rsp_vld !== 4'h0) begin n_bad++; $display("FAIL reset_rsp_vld: got %b want 0000", bus.rsp_vld); end
      n_cmp++; if (bus.mc_rs_stall !== 1'b0) begin n_bad++; $display("FAIL reset_mc_rs_stall: got %b want 0", bus.mc_rs_stall); end
      n_cmp++; if (bus.err_bad_rtnctl !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err_bad_rtnctl); end
      n_cmp++; if (bus.idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b want 1", bus.idle); end
      n_cmp++; if (bus.mc_rq_flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush: got %b want 0", bus.mc_rq_flush); end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.req_vld = '0;
   endtask

   task automatic test_round_robin();
      int exp_g [9];
      int prev;
      int lows [N];
      logic [3:0] es;
      exp_g = '{0, 1, 2, 3, 0, 1, 2, 3, -1};
      prev = -1;
      for (int i = 0; i < N; i++) lows[i] = 0;
      for (int c = 0; c < 9; c++) begin
         bus.req_vld = (c < 8) ? 4'hF : 4'h0;
         sample();
         es = (exp_g[c] < 0) ? 4'hF : ~(4'(1) << exp_g[c]);
         n_cmp++; if (bus.req_stall !== es) begin n_bad++; $display("FAIL rr_req_stall c%0d: got %b want %b", c, bus.req_stall, es); end
         n_cmp++; if (bus.mc_rq_vld !== (prev >= 0)) begin n_bad++; $display("FAIL rr_mc_rq_vld c%0d: got %b want %b", c, bus.mc_rq_vld, prev >= 0); end
         if (prev >= 0) begin
            n_cmp++; if (bus.mc_rq_rtnctl !== {8'(prev), 24'h000100 + 24'(prev)}) begin n_bad++; $display("FAIL rr_rtnctl c%0d: got %h want %h", c, bus.mc_rq_rtnctl, {8'(prev), 24'h000100 + 24'(prev)}); end
            n_cmp++; if (bus.mc_rq_vadr !== 48'h1000_0000 + 48'(prev) * 48'h100) begin n_bad++; $display("FAIL rr_vadr c%0d: got %h", c, bus.mc_rq_vadr); end
            n_cmp++; if (bus.mc_rq_scmd !== 4'(prev)) begin n_bad++; $display("FAIL rr_scmd c%0d: got %h want %h", c, bus.mc_rq_scmd, 4'(prev)); end
         end
         if (c < 8)
            for (int i = 0; i < N; i++) if (bus.req_stall[i] === 1'b0) lows[i]++;
         prev = exp_g[c];
         step();
      end
      for (int i = 0; i < N; i++) begin
         n_cmp++; if (lows[i] != 2) begin n_bad++; $display("FAIL rr_grant_count req%0d: got %0d want 2", i, lows[i]); end
      end
   endtask

   task automatic test_mc_stall();
      int exp_g [9];
      int prev;
      logic [3:0] es;
      exp_g = '{0, 1, 2, -1, -1, -1, 3, 0, -1};
      prev = -1;
      for (int c = 0; c < 9; c++) begin
         bus.req_vld = (c < 8) ? 4'hF : 4'h0;
         bus.mc_rq_stall = (c >= 3 && c <= 5);
         sample();
         es = (exp_g[c] < 0) ? 4'hF : ~(4'(1) << exp_g[c]);
         n_cmp++; if (bus.req_stall !== es) begin n_bad++; $display("FAIL stall_req_stall c%0d: got %b want %b", c, bus.req_stall, es); end
         n_cmp++; if (bus.mc_rq_vld !== (prev >= 0)) begin n_bad++; $display("FAIL stall_mc_rq_vld c%0d: got %b want %b", c, bus.mc_rq_vld, prev >= 0); end
         if (prev >= 0) begin
            n_cmp++; if (bus.mc_rq_rtnctl[31:24] !== 8'(prev)) begin n_bad++; $display("FAIL stall_index c%0d: got %h want %h", c, bus.mc_rq_rtnctl[31:24], 8'(prev)); end
         end
         prev = exp_g[c];
         step();
      end
      bus.mc_rq_stall = 1'b0;
   endtask

   task automatic test_rsp_steering();
      bus.mc_rs_vld = 1'b1; bus.mc_rs_rtnctl = 32'h0200_0055; bus.mc_rs_cmd = 3'd3;
      bus.mc_rs_scmd = 4'h5; bus.mc_rs_data = 64'h1234_5678;
      sample();
      n_cmp++; if (bus.rsp_vld !== 4'b0000) begin n_bad++; $display("FAIL steer_latency: got %b want 0000", bus.rsp_vld); end
      step();
      bus.mc_rs_vld = 1'b0;
      sample();
      n_cmp++; if (bus.rsp_vld !== 4'b0100) begin n_bad++; $display("FAIL steer_vld2: got %b want 0100", bus.rsp_vld); end
      n_cmp++; if (bus.rsp_rtnctl !== 24'h000055) begin n_bad++; $display("FAIL steer_rtnctl: got %h want 000055", bus.rsp_rtnctl); end
      n_cmp++; if (bus.rsp_data !== 64'h1234_5678) begin n_bad++; $display("FAIL steer_data: got %h want 12345678", bus.rsp_data); end
      n_cmp++; if (bus.rsp_cmd !== 3'd3 || bus.rsp_scmd !== 4'h5) begin n_bad++; $display("FAIL steer_cmd: got %h/%h want 3/5", bus.rsp_cmd, bus.rsp_scmd); end
      step();
      bus.mc_rs_vld = 1'b1; bus.mc_rs_rtnctl = 32'h0700_0011;
      sample();
      n_cmp++; if (bus.rsp_vld !== 4'b0000) begin n_bad++; $display("FAIL steer_popped: got %b want 0000", bus.rsp_vld); end
      step();
      bus.mc_rs_vld = 1'b0;
      sample();
      n_cmp++; if (bus.rsp_vld !== 4'b0000) begin n_bad++; $display("FAIL steer_bad_vld: got %b want 0000", bus.rsp_vld); end
      n_cmp++; if (bus.err_bad_rtnctl !== 1'b0) begin n_bad++; $display("FAIL steer_err_early: got %b want 0", bus.err_bad_rtnctl); end
      step();
      sample();
      n_cmp++; if (bus.err_bad_rtnctl !== 1'b1) begin n_bad++; $display("FAIL steer_err_set: got %b want 1", bus.err_bad_rtnctl); end
      n_cmp++; if (bus.idle !== 1'b1) begin n_bad++; $display("FAIL steer_idle: got %b want 1", bus.idle); end
      step();
      bus.mc_rs_vld = 1'b1; bus.mc_rs_rtnctl = 32'h0000_0AAA;
      step();
      bus.mc_rs_rtnctl = 32'h0300_0BBB;
      sample();
      n_cmp++; if (bus.rsp_vld !== 4'b0001 || bus.rsp_rtnctl !== 24'h000AAA) begin n_bad++; $display("FAIL steer_idx0: got %b/%h want 0001/000aaa", bus.rsp_vld, bus.rsp_rtnctl); end
      step();
      bus.mc_rs_vld = 1'b0;
      sample();
      n_cmp++; if (bus.rsp_vld !== 4'b1000 || bus.rsp_rtnctl !== 24'h000BBB) begin n_bad++; $display("FAIL steer_idx3: got %b/%h want 1000/000bbb", bus.rsp_vld, bus.rsp_rtnctl); end
      n_cmp++; if (bus.err_bad_rtnctl !== 1'b1) begin n_bad++; $display("FAIL steer_err_sticky: got %b want 1", bus.err_bad_rtnctl); end
      step();
   endtask

   task automatic test_back_pressure();
      logic exp_st;
      bus.rsp_stall = 4'b0010;
      for (int c = 0; c < 6; c++) begin
         bus.mc_rs_vld = 1'b1; bus.mc_rs_cmd = 3'd3;
         bus.mc_rs_rtnctl = 32'h0100_0000 + 32'(c);
         bus.mc_rs_data = 64'hB000 + 64'(c);
         sample();
         n_cmp++; if (bus.mc_rs_stall !== (c >= 4)) begin n_bad++; $display("FAIL bp_rs_stall_fill c%0d: got %b want %b", c, bus.mc_rs_stall, c >= 4); end
         n_cmp++; if (bus.rsp_vld !== ((c == 0) ? 4'b0000 : 4'b0010)) begin n_bad++; $display("FAIL bp_rsp_vld_fill c%0d: got %b", c, bus.rsp_vld); end
         step();
      end
      bus.mc_rs_vld = 1'b0;
      sample();
      n_cmp++; if (bus.mc_rs_stall !== 1'b1) begin n_bad++; $display("FAIL bp_rs_stall_hold: got %b want 1", bus.mc_rs_stall); end
      n_cmp++; if (bus.rsp_rtnctl !== 24'h000000) begin n_bad++; $display("FAIL bp_head_blocked: got %h want 000000", bus.rsp_rtnctl); end
      step();
      bus.rsp_stall = 4'b0000;
      for (int d = 0; d < 6; d++) begin
         sample();
         exp_st = (d <= 2);
         n_cmp++; if (bus.rsp_vld !== 4'b0010) begin n_bad++; $display("FAIL bp_drain_vld d%0d: got %b want 0010", d, bus.rsp_vld); end
         n_cmp++; if (bus.rsp_rtnctl !== 24'(d) || bus.rsp_data !== 64'hB000 + 64'(d)) begin n_bad++; $display("FAIL bp_drain_order d%0d: got %h/%h", d, bus.rsp_rtnctl, bus.rsp_data); end
         n_cmp++; if (bus.mc_rs_stall !== exp_st) begin n_bad++; $display("FAIL bp_rs_stall_drain d%0d: got %b want %b", d, bus.mc_rs_stall, exp_st); end
         step();
      end
      sample();
      n_cmp++; if (bus.rsp_vld !== 4'b0000 || bus.idle !== 1'b1) begin n_bad++; $display("FAIL bp_empty: got vld %b idle %b want 0000 1", bus.rsp_vld, bus.idle); end
      step();
   endtask

`ifdef MC_ARB_OUTSTANDING_LIMIT_EN
   task automatic test_outstanding();
      int exp_g [6];
      logic [3:0] es;
      exp_g = '{0, 0, 1, 1, 1, 0};
      bus.req_cmd[2:0] = 3'd1;
      for (int c = 0; c < 6; c++) begin
         bus.req_vld = (c < 2) ? 4'b0001 : 4'b0011;
         bus.mc_rs_vld = (c == 3);
         bus.mc_rs_cmd = 3'd2;
         bus.mc_rs_rtnctl = 32'h0000_0777;
         sample();
         es = ~(4'(1) << exp_g[c]);
         n_cmp++; if (bus.req_stall !== es) begin n_bad++; $display("FAIL lim_req_stall c%0d: got %b want %b", c, bus.req_stall, es); end
         if (c == 4) begin
            n_cmp++; if (bus.rsp_vld !== 4'b0001) begin n_bad++; $display("FAIL lim_rd_data: got %b want 0001", bus.rsp_vld); end
         end
         step();
      end
      bus.req_vld = '0;
      bus.mc_rs_vld = 1'b0;
      step();
      sample();
      n_cmp++; if (bus.idle !== 1'b0) begin n_bad++; $display("FAIL lim_idle_busy: got %b want 0", bus.idle); end
      step();
      bus.mc_rs_vld = 1'b1;
      step();
      step();
      bus.mc_rs_vld = 1'b0;
      step();
      sample();
      n_cmp++; if (bus.idle !== 1'b1) begin n_bad++; $display("FAIL lim_idle_done: got %b want 1", bus.idle); end
      step();
      bus.req_cmd[2:0] = 3'd2;
   endtask
`endif

   task automatic test_async_reset();
      bus.req_vld = 4'hF;
      bus.rsp_stall = 4'b0100;
      bus.mc_rs_vld = 1'b1; bus.mc_rs_cmd = 3'd3; bus.mc_rs_rtnctl = 32'h0200_0099;
      step();
      bus.mc_rs_vld = 1'b0;
      sample();
      n_cmp++; if (bus.mc_rq_vld !== 1'b1 || bus.rsp_vld !== 4'b0100) begin n_bad++; $display("FAIL arst_busy: got %b/%b want 1/0100", bus.mc_rq_vld, bus.rsp_vld); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.mc_rq_vld !== 1'b0) begin n_bad++; $display("FAIL arst_mc_rq_vld: got %b want 0", bus.mc_rq_vld); end
      n_cmp++; if (bus.rsp_vld !== 4'b0000) begin n_bad++; $display("FAIL arst_rsp_vld: got %b want 0000", bus.rsp_vld); end
      n_cmp++; if (bus.req_stall !== 4'hF) begin n_bad++; $display("FAIL arst_req_stall: got %b want 1111", bus.req_stall); end
      n_cmp++; if (bus.err_bad_rtnctl !== 1'b0) begin n_bad++; $display("FAIL arst_err: got %b want 0", bus.err_bad_rtnctl); end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.req_vld = '0;
      bus.rsp_stall = '0;
      sample();
      n_cmp++; if (bus.idle !== 1'b1 || bus.rsp_vld !== 4'b0000 || bus.mc_rs_stall !== 1'b0) begin n_bad++; $display("FAIL arst_release: got idle %b vld %b stall %b", bus.idle, bus.rsp_vld, bus.mc_rs_stall); end
      step();
      bus.req_vld = 4'hF;
      sample();
      n_cmp++; if (bus.req_stall !== 4'b1110) begin n_bad++; $display("FAIL arst_ptr: got %b want 1110", bus.req_stall); end
      step();
      bus.req_vld = '0;
      step();
   endtask

   initial begin
      init_inputs();
      test_reset();
      test_round_robin();
      test_mc_stall();
      test_rsp_steering();
      test_back_pressure();
`ifdef MC_ARB_OUTSTANDING_LIMIT_EN
      test_outstanding();
`endif
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end
endmodule
